sq_iter_ctrl: RTL and testbench

//  Iteration sequencer for the modular-squaring datapath (partial-product gen -> PP accumulation ->

---
 rtl/sq_pkg.sv | 24 ++
 rtl/sq_wdog.sv | 53 +++++
 rtl/sq_iter_ctrl.sv | 138 +++++++++++++
 tb/tb_sq_iter_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_pkg.sv
// ============================================================================
// Module   : sq_pkg
// Purpose  : Shared types and constants for the modular-squaring sequencer
//            and its datapath top.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sq_pkg;

  localparam int unsigned SQ_PIPE_LAT = 4;
  localparam int unsigned SQ_CNT_W    = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } sq_state_t;

endpackage : sq_pkg

`default_nettype wire

// File: rtl/sq_wdog.sv
// ============================================================================
// Module   : sq_wdog
// Purpose  : Loadable down-counter flagging a datapath result that never came.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_wdog #(
  parameter int unsigned TIMEOUT = 12
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned c_cnt_w = $clog2(TIMEOUT + 1);
  // expire_o rises in the cycle TIMEOUT-1 after the load cycle
  localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(TIMEOUT - 2);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("sq_wdog: TIMEOUT must be at least 2");
  end

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = c_load_val;
      armed_d = 1'b1;
    end else if (armed_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expire_o = armed_q && (cnt_q == '0);

endmodule : sq_wdog

`default_nettype wire

// File: rtl/sq_iter_ctrl.sv
// ============================================================================
// Module   : sq_iter_ctrl
// Purpose  : Iteration sequencer issuing T back-to-back squarings with
//            result feedback and a hold-until-ack completion handshake.
//            Optional checkpoint pulses enabled by `SQ_CKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_iter_ctrl
  import sq_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = SQ_PIPE_LAT,
  parameter int unsigned CNT_W      = SQ_CNT_W,
  parameter int unsigned WDOG_SLACK = 8,
  parameter int unsigned CKPT_LOG2  = 20
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] t_in_i,
  input  logic             abort_i,
  output logic             start_rdy_o,
  output logic             dp_load_o,
  output logic             dp_issue_o,
  output logic             dp_fb_sel_o,
  input  logic             dp_valid_i,
  output logic [CNT_W-1:0] iter_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic             done_ack_i,
  output logic             err_o,
  output logic             ckpt_o
);

  if (CKPT_LOG2 > CNT_W) begin : g_ckpt_log2_chk
    $error("sq_iter_ctrl: CKPT_LOG2 exceeds CNT_W");
  end

  sq_state_t        state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] w_iter_inc;
  logic             w_wdog_expire;
  logic             w_abort;

  assign w_iter_inc = (&iter_q) ? iter_q : iter_q + CNT_W'(1);
  assign w_abort    = abort_i && (state_q != IDLE);

  sq_wdog #(
    .TIMEOUT (PIPE_LAT + WDOG_SLACK)
  ) u_wdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (dp_issue_o),
    .expire_o (w_wdog_expire)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    iter_d  = iter_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          t_d     = t_in_i;
          iter_d  = '0;
          err_d   = 1'b0;
          state_d = (t_in_i == '0) ? DONE : LOAD;
        end
      end
      LOAD:  state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (dp_valid_i) begin
          iter_d  = w_iter_inc;
          state_d = (w_iter_inc == t_q) ? DONE : ISSUE;
        end else if (w_wdog_expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A result outside WAIT has no owner; the job itself carries on
    if (dp_valid_i && (state_q != WAIT)) err_d = 1'b1;

    if (w_abort) begin
      state_d = IDLE;
      iter_d  = iter_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  assign start_rdy_o = (state_q == IDLE);
  assign busy_o      = (state_q == LOAD) || (state_q == ISSUE) || (state_q == WAIT);
  assign done_o      = (state_q == DONE);
  assign dp_load_o   = (state_q == LOAD) && !abort_i;
  assign dp_issue_o  = (state_q == ISSUE) && !abort_i;
  assign dp_fb_sel_o = (state_q == ISSUE) && (iter_q != '0);
  assign iter_cnt_o  = iter_q;
  assign err_o       = err_q;

`ifdef SQ_CKPT_EN
  localparam logic [CNT_W-1:0] c_ckpt_mask = (CNT_W'(1) << CKPT_LOG2) - CNT_W'(1);

  // Same cycle as the result so the host can snapshot it; never on the last one
  assign ckpt_o = (state_q == WAIT) && dp_valid_i && !abort_i &&
                  ((w_iter_inc & c_ckpt_mask) == '0) && (w_iter_inc != t_q);
`else
  assign ckpt_o = 1'b0;
`endif

endmodule : sq_iter_ctrl

`default_nettype wire

// File: tb/tb_sq_iter_ctrl.sv
// ============================================================================
// Module   : tb_sq_iter_ctrl
// Purpose  : Scoreboard bench for sq_iter_ctrl with a latency-accurate
//            datapath stand-in. Checkpoint expectations follow `SQ_CKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sq_iter_ctrl;

  localparam int PIPE_LAT = 4;
  localparam int CNT_W    = 64;

  localparam int EV_LOAD  = 0;
  localparam int EV_ISSUE = 1;
  localparam int EV_CKPT  = 2;
  localparam int EV_DONE  = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] t_in;
  logic             abort;
  logic             start_rdy_o, dp_load_o, dp_issue_o, dp_fb_sel_o;
  logic             dp_valid;
  logic [CNT_W-1:0] iter_cnt_o;
  logic             busy_o, done_o, err_o, ckpt_o;
  logic             done_ack;

  sq_iter_ctrl #(
    .PIPE_LAT   (PIPE_LAT),
    .CNT_W      (CNT_W),
    .WDOG_SLACK (8),
    .CKPT_LOG2  (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .t_in_i      (t_in),
    .abort_i     (abort),
    .start_rdy_o (start_rdy_o),
    .dp_load_o   (dp_load_o),
    .dp_issue_o  (dp_issue_o),
    .dp_fb_sel_o (dp_fb_sel_o),
    .dp_valid_i  (dp_valid),
    .iter_cnt_o  (iter_cnt_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .done_ack_i  (done_ack),
    .err_o       (err_o),
    .ckpt_o      (ckpt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              kind;
    int              rel;
    longint unsigned val;
    bit              flag;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  s0 = 0;
  int  ckpt_seen = 0;
  bit  done_prev = 1'b0;

  // datapath stand-in controls
  int  valid_at = -1;
  int  issue_n = 0;
  int  valid_n = 0;
  int  withhold_issue = 0;
  int  abort_on_valid = 0;
  bit  force_valid = 1'b0;

  function automatic void exp_ev(int k, int r, longint unsigned v, bit f);
    ev_t e;
    e.kind = k; e.rel = r; e.val = v; e.flag = f;
    sb.push_back(e);
  endfunction

  task automatic chk(string nm, longint unsigned got, longint unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic mon(int k, longint unsigned v, bit f);
    ev_t e;
    int  rel;
    rel = cyc - s0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d rel=%0d val=%0d flag=%0d expected none",
               k, rel, v, f);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.rel != rel || e.val != v || e.flag != f) begin
        errors++;
        $display("FAIL event: got kind=%0d rel=%0d val=%0d flag=%0d expected kind=%0d rel=%0d val=%0d flag=%0d",
                 k, rel, v, f, e.kind, e.rel, e.val, e.flag);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dp_load_o)  mon(EV_LOAD, 0, dp_fb_sel_o);
      if (dp_issue_o) mon(EV_ISSUE, 0, dp_fb_sel_o);
      if (ckpt_o) begin
        ckpt_seen++;
        mon(EV_CKPT, iter_cnt_o, 1'b0);
      end
      if (done_o && !done_prev) mon(EV_DONE, iter_cnt_o, err_o);
    end
    done_prev = done_o;
  end

  // Result returns PIPE_LAT cycles after the issue, unless withheld
  always @(negedge clk) begin
    if (dp_issue_o) begin
      issue_n = issue_n + 1;
      if (issue_n != withhold_issue) valid_at = cyc + PIPE_LAT;
    end
  end

  initial begin
    dp_valid = 1'b0;
    abort    = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      dp_valid = force_valid || (valid_at == cyc);
      if (dp_valid && !force_valid) begin
        valid_n = valid_n + 1;
        abort   = (valid_n == abort_on_valid);
      end else begin
        abort = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(longint unsigned t);
    issue_n = 0;
    valid_n = 0;
    t_in    = t;
    start   = 1'b1;
    s0      = cyc;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(int limit);
    for (int i = 0; i < limit && !done_o; i++) step();
    checks++;
    if (!done_o) begin
      errors++;
      $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", limit);
    end
  endtask

  task automatic finish_job(int limit);
    wait_done(limit);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; t_in = '0; done_ack = 1'b0;
    step(); step();
    chk("rst_start_rdy", start_rdy_o, 1);
    chk("rst_busy",      busy_o, 0);
    chk("rst_done",      done_o, 0);
    chk("rst_err",       err_o, 0);
    chk("rst_ckpt",      ckpt_o, 0);
    chk("rst_load",      dp_load_o, 0);
    chk("rst_issue",     dp_issue_o, 0);
    chk("rst_fb_sel",    dp_fb_sel_o, 0);
    chk("rst_iter",      iter_cnt_o, 0);
    reset = 1'b0;
    step();

    // T=3: issues at 2,7,12; done at 17
    exp_ev(EV_LOAD, 1, 0, 0);
    exp_ev(EV_ISSUE, 2, 0, 0);
    exp_ev(EV_ISSUE, 7, 0, 1);
    exp_ev(EV_ISSUE, 12, 0, 1);
    exp_ev(EV_DONE, 17, 3, 0);
    begin_job(3);
    finish_job(100);
    chk("t3_iter", iter_cnt_o, 3);
    chk("t3_state_idle", start_rdy_o, 1);

    // T=0: straight to DONE, seed is the result
    exp_ev(EV_DONE, 1, 0, 0);
    begin_job(0);
    finish_job(20);
    chk("t0_err", err_o, 0);

    // T=5 with the second result withheld: watchdog ends the job
    withhold_issue = 2;
    exp_ev(EV_LOAD, 1, 0, 0);
    exp_ev(EV_ISSUE, 2, 0, 0);
    exp_ev(EV_ISSUE, 7, 0, 1);
    exp_ev(EV_DONE, 19, 1, 1);
    begin_job(5);
    finish_job(100);
    withhold_issue = 0;
    chk("wdog_err", err_o, 1);
    chk("wdog_iter", iter_cnt_o, 1);

    // T=10 with abort on the 4th result
    abort_on_valid = 4;
    exp_ev(EV_LOAD, 1, 0, 0);
    exp_ev(EV_ISSUE, 2, 0, 0);
    exp_ev(EV_ISSUE, 7, 0, 1);
    exp_ev(EV_ISSUE, 12, 0, 1);
    exp_ev(EV_ISSUE, 17, 0, 1);
    begin_job(10);
    for (int i = 0; i < 100 && !start_rdy_o; i++) step();
    abort_on_valid = 0;
    chk("abort_idle_cycle", cyc - s0, 22);
    chk("abort_iter", iter_cnt_o, 3);
    chk("abort_err", err_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_busy", busy_o, 0);
    repeat (5) step();
    chk("abort_sb_empty", sb.size(), 0);

    // T=1 with start held through 20 cycles of DONE
    exp_ev(EV_LOAD, 1, 0, 0);
    exp_ev(EV_ISSUE, 2, 0, 0);
    exp_ev(EV_DONE, 7, 1, 0);
    issue_n = 0; valid_n = 0;
    t_in  = 1;
    start = 1'b1;
    s0    = cyc;
    step();
    wait_done(50);
    repeat (20) step();
    chk("hold_done", done_o, 1);
    chk("hold_start_rdy", start_rdy_o, 0);
    exp_ev(EV_LOAD, 2, 0, 0);
    exp_ev(EV_ISSUE, 3, 0, 0);
    exp_ev(EV_DONE, 8, 1, 0);
    issue_n = 0; valid_n = 0;
    done_ack = 1'b1;
    s0 = cyc;
    step();
    done_ack = 1'b0;
    step();
    start = 1'b0;
    finish_job(50);

    // T=9 checkpoint pattern
    exp_ev(EV_LOAD, 1, 0, 0);
    for (int k = 0; k < 9; k++) begin
      exp_ev(EV_ISSUE, 2 + 5 * k, 0, (k != 0));
`ifdef SQ_CKPT_EN
      if (((k + 1) % 4) == 0) exp_ev(EV_CKPT, 6 + 5 * k, k, 0);
`endif
    end
    exp_ev(EV_DONE, 47, 9, 0);
    begin_job(9);
    finish_job(200);
`ifdef SQ_CKPT_EN
    chk("ckpt_count", ckpt_seen, 2);
`else
    chk("ckpt_count", ckpt_seen, 0);
`endif

    // Spurious result while idle
    chk("pre_spur_err", err_o, 0);
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    step();
    chk("spur_err", err_o, 1);
    chk("spur_start_rdy", start_rdy_o, 1);
    chk("spur_busy", busy_o, 0);
    chk("spur_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sq_iter_ctrl

`default_nettype wire
